// File: rtl/vnu_control_unit_if.sv
// vnu_control_unit_if: handshake and status bundle between the CNU side and the VNU control FSM
interface vnu_control_unit_if #(
   parameter int MAX_ITER      = 10,
   parameter int FSM_STATE_NUM = 5
);
   logic                               fsm_en;
   logic                               c2v_mem_we;
   logic                               last_layer;
   logic                               syndrome_zero;
   logic                               vnu_rd;
   logic                               v2c_fetch;
   logic                               v2c_mem_we;
   logic                               layer_finish;
   logic                               vnu_update_pend;
   logic                               termination;
   logic [$clog2(MAX_ITER+1)-1:0]      iter_cnt;
   logic                               err_overrun;
   logic [$clog2(FSM_STATE_NUM)-1:0]   state;
   modport master (
      output fsm_en, c2v_mem_we, last_layer, syndrome_zero,
      input  vnu_rd, v2c_fetch, v2c_mem_we, layer_finish, vnu_update_pend,
             termination, iter_cnt, err_overrun, state
   );
   modport slave (
      input  fsm_en, c2v_mem_we, last_layer, syndrome_zero,
      output vnu_rd, v2c_fetch, v2c_mem_we, layer_finish, vnu_update_pend,
             termination, iter_cnt, err_overrun, state
   );
endinterface

// File: rtl/vnu_control_unit.sv
// vnu_control_unit: sequences VNU fetch, pipeline and v2c write-back per layer, tracks iterations and termination
module vnu_control_unit #(
   parameter int LAYER_NUM          = 3,
   parameter int MAX_ITER           = 10,
   parameter int MEM_RD_LEVEL       = 2,
   parameter int VNU_PIPELINE_LEVEL = 3,
   parameter int IB_LOAD_CYCLE      = 4,
   parameter int FSM_STATE_NUM      = 5
) (
   input logic                read_clk,
   input logic                rst,
   vnu_control_unit_if.slave  bus
);
   localparam int SW   = $clog2(FSM_STATE_NUM);
   localparam int IW   = $clog2(MAX_ITER + 1);
   localparam int CW_A = MEM_RD_LEVEL > VNU_PIPELINE_LEVEL ? MEM_RD_LEVEL : VNU_PIPELINE_LEVEL;
   localparam int CW   = CW_A > IB_LOAD_CYCLE ? CW_A : IB_LOAD_CYCLE;

   if (LAYER_NUM < 1 || MEM_RD_LEVEL < 1 || VNU_PIPELINE_LEVEL < 1 || IB_LOAD_CYCLE < 1 || FSM_STATE_NUM < 5) begin : g_param_check
      $error("vnu_control_unit: invalid parameter value");
   end

   typedef enum logic [SW-1:0] {
      V_IDLE      = 0,
      V_MEM_FETCH = 1,
      V_PIPE      = 2,
      V_WB        = 3,
      V_IB_UPDATE = 4
   } state_t;

   state_t          st, st_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [IW-1:0]   iter_cnt;
   logic            ll_q;
   logic            err_overrun;
   logic            term_cond;

   assign bus.state       = st;
   assign bus.iter_cnt    = iter_cnt;
   assign bus.err_overrun = err_overrun;

   // state, one-hot dwell counter, latched layer flag, iteration count and sticky overrun flag
   always_ff @(posedge read_clk or posedge rst) begin
      if (rst) begin
         st          <= V_IDLE;
         cnt         <= '0;
         ll_q        <= 1'b0;
         iter_cnt    <= '0;
         err_overrun <= 1'b0;
      end else if (!bus.fsm_en) begin
         st          <= V_IDLE;
         cnt         <= '0;
         ll_q        <= 1'b0;
         iter_cnt    <= '0;
         err_overrun <= 1'b0;
      end else begin
         st  <= st_nxt;
         cnt <= cnt_nxt;
         if (st == V_IDLE && bus.c2v_mem_we)
            ll_q <= bus.last_layer;
         if (st != V_IDLE && bus.c2v_mem_we)
            err_overrun <= 1'b1;
         if (st == V_WB && ll_q)
            iter_cnt <= term_cond ? '0 : iter_cnt + IW'(1);
      end
   end

   // next state, dwell-counter shift and state-decoded strobes
   always_comb begin
      st_nxt              = st;
      cnt_nxt             = cnt << 1;
      term_cond           = bus.syndrome_zero | (iter_cnt == IW'(MAX_ITER - 1));
      bus.v2c_fetch       = 1'b0;
      bus.vnu_rd          = 1'b0;
      bus.v2c_mem_we      = 1'b0;
      bus.layer_finish    = 1'b0;
      bus.termination     = 1'b0;
      bus.vnu_update_pend = 1'b0;
      case (st)
         V_IDLE: begin
            if (bus.c2v_mem_we) begin
               st_nxt  = V_MEM_FETCH;
               cnt_nxt = CW'(1);
            end
         end
         V_MEM_FETCH: begin
            bus.v2c_fetch = cnt[0];
            if (cnt[MEM_RD_LEVEL-1]) begin
               st_nxt  = V_PIPE;
               cnt_nxt = CW'(1);
            end
         end
         V_PIPE: begin
            bus.vnu_rd = 1'b1;
            if (cnt[VNU_PIPELINE_LEVEL-1]) begin
               st_nxt  = V_WB;
               cnt_nxt = CW'(1);
            end
         end
         V_WB: begin
            bus.v2c_mem_we      = 1'b1;
            bus.layer_finish    = 1'b1;
            bus.termination     = ll_q & term_cond;
            bus.vnu_update_pend = ll_q & ~term_cond;
            st_nxt              = (ll_q & ~term_cond) ? V_IB_UPDATE : V_IDLE;
            cnt_nxt             = CW'(1);
         end
         V_IB_UPDATE: begin
            bus.vnu_update_pend = 1'b1;
            if (cnt[IB_LOAD_CYCLE-1])
               st_nxt = V_IDLE;
         end
         default: st_nxt = V_IDLE;
      endcase
   end
endmodule

// File: tb/tb_vnu_control_unit.sv
// tb_vnu_control_unit: randomized and directed checks of vnu_control_unit against a layer-timeline reference model
module tb_vnu_control_unit;
   localparam int MAX_ITER = 10;
   localparam int MEM      = 2;
   localparam int PIPE     = 3;
   localparam int IB       = 4;
   localparam int WB_T     = 1 + MEM + PIPE;

   logic read_clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   bit   m_busy, m_last, m_err;
   int   m_t, m_iter;
   int   lf_dut, term_at;

   always #5 read_clk = ~read_clk;

   vnu_control_unit_if #(.MAX_ITER(MAX_ITER), .FSM_STATE_NUM(5)) bus ();

   vnu_control_unit #(
      .LAYER_NUM(3), .MAX_ITER(MAX_ITER), .MEM_RD_LEVEL(MEM),
      .VNU_PIPELINE_LEVEL(PIPE), .IB_LOAD_CYCLE(IB), .FSM_STATE_NUM(5)
   ) dut (
      .read_clk(read_clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // one clock cycle: drive inputs, compare against the layer timeline, advance the model past the edge
   task automatic cycle(input bit we, input bit ll, input bit sz, input bit en);
      bit wb, tc;
      int st;
      bus.c2v_mem_we    = we;
      bus.last_layer    = ll;
      bus.syndrome_zero = sz;
      bus.fsm_en        = en;
      #3;
      wb = m_busy && m_t == WB_T;
      tc = m_last && (sz || m_iter + 1 == MAX_ITER);
      st = !m_busy ? 0 : m_t <= MEM ? 1 : m_t <= MEM + PIPE ? 2 : m_t == WB_T ? 3 : 4;
      check("state", 32'(bus.state), 32'(st));
      check("v2c_fetch", 32'(bus.v2c_fetch), 32'(m_busy && m_t == 1));
      check("vnu_rd", 32'(bus.vnu_rd), 32'(m_busy && m_t > MEM && m_t <= MEM + PIPE));
      check("v2c_mem_we", 32'(bus.v2c_mem_we), 32'(wb));
      check("layer_finish", 32'(bus.layer_finish), 32'(wb));
      check("termination", 32'(bus.termination), 32'(wb && tc));
      check("vnu_update_pend", 32'(bus.vnu_update_pend), 32'(m_busy && ((wb && m_last && !tc) || m_t > WB_T)));
      check("iter_cnt", 32'(bus.iter_cnt), 32'(m_iter));
      check("err_overrun", 32'(bus.err_overrun), 32'(m_err));
      if (bus.layer_finish === 1'b1) lf_dut++;
      if (bus.termination === 1'b1 && term_at < 0) term_at = lf_dut;
      if (!en) begin
         m_busy = 0; m_iter = 0; m_err = 0; m_last = 0;
      end else if (!m_busy) begin
         if (we) begin m_busy = 1; m_t = 1; m_last = ll; end
      end else begin
         if (we) m_err = 1;
         if (wb) begin
            if (m_last) m_iter = tc ? 0 : m_iter + 1;
            if (m_last && !tc) m_t++;
            else m_busy = 0;
         end else if (m_t == WB_T + IB) m_busy = 0;
         else m_t++;
      end
      @(posedge read_clk);
      #1;
   endtask

   task automatic idle(input int n, input bit sz);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, sz, 1'b1);
   endtask

   initial begin
      rst = 1'b1;
      bus.fsm_en = 1'b0; bus.c2v_mem_we = 1'b0; bus.last_layer = 1'b0; bus.syndrome_zero = 1'b0;
      m_busy = 0; m_last = 0; m_err = 0; m_t = 0; m_iter = 0; lf_dut = 0; term_at = -1;
      #12;
      check("rst_state", 32'(bus.state), 0);
      check("rst_iter", 32'(bus.iter_cnt), 0);
      check("rst_err", 32'(bus.err_overrun), 0);
      check("rst_pend", 32'(bus.vnu_update_pend), 0);
      check("rst_lf", 32'(bus.layer_finish), 0);
      rst = 1'b0;
      @(posedge read_clk);
      #1;
      // non-last layer
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      idle(10, 1'b0);
      // last layer without termination, full IB reload
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      idle(12, 1'b0);
      // early stop on zero syndrome
      cycle(1'b1, 1'b1, 1'b1, 1'b1);
      idle(8, 1'b1);
      // overrun during V_PIPE, then clear by disabling
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      idle(2, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      idle(6, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      idle(2, 1'b0);
      // max iteration: 10 iterations of 3 layers, syndrome never zero
      lf_dut = 0; term_at = -1;
      for (int l = 0; l < 30; l++) begin
         cycle(1'b1, l % 3 == 2, 1'b0, 1'b1);
         for (int k = 0; k < 20 && m_busy; k++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
      end
      check("max_iter_term_layer", 32'(term_at), 30);
      check("max_iter_lf_total", 32'(lf_dut), 30);
      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         bit en, we;
         en = ($urandom % 64) != 0;
         we = m_busy ? ($urandom % 25 == 0) : ($urandom % 3 == 0);
         cycle(we, $urandom % 3 == 0, $urandom % 7 == 0, en);
      end
      // asynchronous reset during the IB update
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      idle(7, 1'b0);
      #2;
      check("pre_arst_pend", 32'(bus.vnu_update_pend), 1);
      check("pre_arst_iter", 32'(bus.iter_cnt), 1);
      rst = 1'b1;
      #1;
      check("arst_pend", 32'(bus.vnu_update_pend), 0);
      check("arst_state", 32'(bus.state), 0);
      check("arst_iter", 32'(bus.iter_cnt), 0);
      #20;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/vnu_control_unit.md
Name: vnu_control_unit

Overview:
- Downstream companion of the CNU control FSM in the layered decoder.
- Consumes the CNU's c2v write-back strobe (c2v_mem_we) and last_layer flag, sequences the VNU fetch, pipeline and v2c write-back for the layer, then returns layer_finish.
- After the last layer of an iteration, holds vnu_update_pend while the VNU IB-RAMs reload.
- Counts iterations and issues termination on max-iteration or zero syndrome.

Parameters:
- LAYER_NUM, 3, layers per iteration (informational; layer position comes from last_layer).
- MAX_ITER, 10, maximum decoding iterations per frame.
- MEM_RD_LEVEL, 2, c2v memory fetch latency in cycles.
- VNU_PIPELINE_LEVEL, 3, VNU datapath latency in cycles.
- IB_LOAD_CYCLE, 4, cycles needed to reload the VNU IB-RAMs after the last layer.
- FSM_STATE_NUM, 5, number of FSM states.

Ports:
- read_clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous active-high reset
- fsm_en  input  1  block enable; low forces V_IDLE synchronously
- c2v_mem_we  input  1  one-cycle strobe from CNU FSM: c2v messages of the current layer are written
- last_layer  input  1  high while the current layer is the last of the iteration; sampled with c2v_mem_we
- syndrome_zero  input  1  syndrome check result, sampled in V_WB of the last layer
- vnu_rd  output  1  VNU pipeline active, in V_PIPE
- v2c_fetch  output  1  c2v memory read enable, first V_MEM_FETCH cycle only
- v2c_mem_we  output  1  v2c memory write enable, in V_WB
- layer_finish  output  1  one-cycle pulse, layer complete
- vnu_update_pend  output  1  IB-RAM reload in progress
- termination  output  1  one-cycle pulse, frame decoding finished
- iter_cnt  output  $clog2(MAX_ITER+1)  completed-iteration count, binary
- err_overrun  output  1  sticky: c2v_mem_we arrived outside V_IDLE
- state  output  $clog2(FSM_STATE_NUM)  current FSM state

Behaviour:
- Reset values:
  - state = V_IDLE, iter_cnt = 0, err_overrun = 0.
  - All strobes are 0, and the latched last_layer flag (ll_q) is 0.
  - Reset mid-operation aborts immediately; no partial pulses.
- States: V_IDLE=0, V_MEM_FETCH=1, V_PIPE=2, V_WB=3, V_IB_UPDATE=4. Any other encoding goes to V_IDLE.
- V_IDLE:
  - On c2v_mem_we=1, capture ll_q <= last_layer and go to V_MEM_FETCH.
  - Clear the one-hot sub-counter on entry to each multi-cycle state.
- V_MEM_FETCH: stays exactly MEM_RD_LEVEL cycles (one-hot shift counter), then goes to V_PIPE. v2c_fetch is high in the first cycle only.
- V_PIPE: stays exactly VNU_PIPELINE_LEVEL cycles, then goes to V_WB. vnu_rd is high throughout.
- V_WB: lasts one cycle. v2c_mem_we = 1 and layer_finish = 1 (combinational from state).
  - If ll_q=1: iter_cnt increments at the end of the cycle.
    - term_cond = syndrome_zero OR (iter_cnt+1 == MAX_ITER).
    - If term_cond: termination = 1 in this cycle, vnu_update_pend = 0, next state V_IDLE, iter_cnt <= 0 (clear has priority over increment).
    - Else: vnu_update_pend = 1 in this cycle and next state is V_IB_UPDATE.
  - If ll_q=0: next state V_IDLE; syndrome_zero is ignored.
- V_IB_UPDATE: stays IB_LOAD_CYCLE cycles with vnu_update_pend=1, then goes to V_IDLE. The CNU FSM samples vnu_update_pend together with layer_finish, so it must be high in the V_WB cycle.
- Latency with defaults: c2v_mem_we in cycle 0.
  - v2c_fetch in cycle 1.
  - vnu_rd in cycles 3–5.
  - layer_finish / v2c_mem_we in cycle 6.
  - vnu_update_pend in cycles 6–10 (last layer, no termination).
  - Back to V_IDLE in cycle 7, or cycle 11 after an IB update.
- Overrun: c2v_mem_we while state != V_IDLE is ignored (no restart) and sets err_overrun. err_overrun clears only on rst or fsm_en=0.
- fsm_en=0: state goes to V_IDLE on the next edge; iter_cnt and ll_q clear; outputs follow state.
- Widths: iter_cnt wraps never; termination guarantees clear at MAX_ITER.

Test Plan:
- Non-last layer: rst pulse, fsm_en=1, c2v_mem_we at cycle 0 with last_layer=0.
  - Expect v2c_fetch in cycle 1, vnu_rd in cycles 3–5, layer_finish and v2c_mem_we only in cycle 6.
  - Expect vnu_update_pend=0, iter_cnt stays 0.
- Last layer, syndrome_zero=0, iter_cnt=0:
  - Expect layer_finish in cycle 6, vnu_update_pend high in cycles 6–10, iter_cnt=1 in cycle 7, state V_IDLE in cycle 11, termination never asserted.
- Early stop: last layer with syndrome_zero=1 in cycle 6.
  - Expect termination=1 only in cycle 6, vnu_update_pend=0, iter_cnt=0 in cycle 7.
- Max iteration: run 10 full iterations of 3 layers each with syndrome_zero=0.
  - Expect termination on the 30th layer_finish, and iter_cnt to read 1..9 after iterations 1–9 and then return to 0.
- Overrun: second c2v_mem_we in cycle 3 (V_PIPE).
  - Expect timing unchanged (layer_finish still in cycle 6) and err_overrun=1 held until fsm_en=0.
- Async reset: assert rst asynchronously in cycle 8 of the IB update.
  - Expect vnu_update_pend=0, state=V_IDLE and iter_cnt=0 immediately, without waiting for a read_clk edge.
